// File: rtl/enc_regs_pkg.sv
// Register map, bit positions and control struct shared by the encoder
// AXI4-Lite responder and its bench.
package enc_regs_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_POS    = 2'd1;
  localparam logic [1:0] REG_PRESET = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_INV  = 1;
  localparam int CTRL_ZCLR = 2;
  localparam int CTRL_LOAD = 3;

  localparam int ST_DIR = 0;
  localparam int ST_ERR = 1;
  localparam int ST_IDX = 2;

  // Field order matches CTRL bits [2:0] so the struct reads back directly.
  typedef struct packed {
    logic zclr;
    logic inv;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = strb[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// Quadrature front end: 2-FF synchronizers on A/B/Z, x4 Gray transition
// decode into single-cycle up/dn/err pulses and a Z rising-edge pulse.
module quad_decoder (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic z,
  output logic up,
  output logic dn,
  output logic err,
  output logic idx
);

  logic [1:0] ab_s1, ab_s2, ab_prev;
  logic       z_s1, z_s2, z_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_s1   <= '0;
      ab_s2   <= '0;
      ab_prev <= '0;
      z_s1    <= 1'b0;
      z_s2    <= 1'b0;
      z_prev  <= 1'b0;
    end else begin
      ab_s1   <= {a, b};
      ab_s2   <= ab_s1;
      ab_prev <= ab_s2;
      z_s1    <= z;
      z_s2    <= z_s1;
      z_prev  <= z_s2;
    end
  end

  // {prev, cur}: forward is 00->01->11->10->00, two-bit flips are illegal.
  always_comb begin
    up  = 1'b0;
    dn  = 1'b0;
    err = 1'b0;
    case ({ab_prev, ab_s2})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: up  = 1'b1;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: dn  = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: err = 1'b1;
      default: ;
    endcase
  end

  assign idx = z_s2 & ~z_prev;

endmodule

// File: rtl/encoder_axil_slave.sv
// AXI4-Lite register front end for the quadrature encoder counter.
// Define ENC_INDEX_EN to add the ENC_Z pin, CTRL.ZCLR and STATUS.IDX.
module encoder_axil_slave
  import enc_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            ENC_A,
  input  logic                            ENC_B
`ifdef ENC_INDEX_EN
  , input logic                           ENC_Z
`endif
);

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wst_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} rst_t;

  wst_t        wst;
  rst_t        rst;
  ctrl_t       ctrl;
  logic [31:0] pos, preset, rd_mux;
  logic        dir_q, err_q, idx_q;
  logic        dec_up, dec_dn, dec_err, dec_idx, enc_z;
  logic        wr_hs, rd_hs, load, idx_clr, cnt_up, cnt_dn, st_w1c;
  logic [1:0]  wr_sel;

`ifdef ENC_INDEX_EN
  assign enc_z = ENC_Z;
`else
  assign enc_z = 1'b0;
`endif

  quad_decoder u_dec (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .a     (ENC_A),
    .b     (ENC_B),
    .z     (enc_z),
    .up    (dec_up),
    .dn    (dec_dn),
    .err   (dec_err),
    .idx   (dec_idx)
  );

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  assign wr_hs  = (wst == W_ACK) && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs  = (rst == R_ACK) && S_AXI_ARVALID;
  assign wr_sel = S_AXI_AWADDR[3:2];

  // Write channel: ready is a one-cycle pulse; a pending write may be
  // accepted right after the B handshake without passing through idle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wst           <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
    end else begin
      case (wst)
        W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) begin
          wst           <= W_ACK;
          S_AXI_AWREADY <= 1'b1;
          S_AXI_WREADY  <= 1'b1;
        end
        W_ACK: begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          if (wr_hs) begin
            wst          <= W_RESP;
            S_AXI_BVALID <= 1'b1;
          end else begin
            wst <= W_IDLE;
          end
        end
        W_RESP: if (S_AXI_BREADY) begin
          S_AXI_BVALID <= 1'b0;
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            wst           <= W_ACK;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
          end else begin
            wst <= W_IDLE;
          end
        end
        default: wst <= W_IDLE;
      endcase
    end
  end

  // Read channel mirrors the write side; RDATA is frozen at the AR handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst           <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      case (rst)
        R_IDLE: if (S_AXI_ARVALID) begin
          rst           <= R_ACK;
          S_AXI_ARREADY <= 1'b1;
        end
        R_ACK: begin
          S_AXI_ARREADY <= 1'b0;
          if (rd_hs) begin
            rst          <= R_RESP;
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_mux;
          end else begin
            rst <= R_IDLE;
          end
        end
        R_RESP: if (S_AXI_RREADY) begin
          S_AXI_RVALID <= 1'b0;
          if (S_AXI_ARVALID) begin
            rst           <= R_ACK;
            S_AXI_ARREADY <= 1'b1;
          end else begin
            rst <= R_IDLE;
          end
        end
        default: rst <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      REG_CTRL:   rd_mux[CTRL_ZCLR:CTRL_EN] = ctrl;
      REG_POS:    rd_mux = pos;
      REG_PRESET: rd_mux = preset;
      REG_STATUS: begin
        rd_mux[ST_DIR] = dir_q;
        rd_mux[ST_ERR] = err_q;
        rd_mux[ST_IDX] = idx_q;
      end
      default: ;
    endcase
  end

  assign load   = wr_hs && (wr_sel == REG_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[CTRL_LOAD];
  assign st_w1c = wr_hs && (wr_sel == REG_STATUS) && S_AXI_WSTRB[0];
  // INV swaps which decoder pulse increments the counter.
  assign cnt_up = ctrl.en && (ctrl.inv ? dec_dn : dec_up);
  assign cnt_dn = ctrl.en && (ctrl.inv ? dec_up : dec_dn);
`ifdef ENC_INDEX_EN
  assign idx_clr = dec_idx && ctrl.en && ctrl.zclr;
`else
  assign idx_clr = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl   <= '0;
      preset <= '0;
      pos    <= '0;
      dir_q  <= 1'b0;
      err_q  <= 1'b0;
      idx_q  <= 1'b0;
    end else begin
      if (wr_hs) begin
        case (wr_sel)
          REG_CTRL: if (S_AXI_WSTRB[0]) begin
            ctrl.en  <= S_AXI_WDATA[CTRL_EN];
            ctrl.inv <= S_AXI_WDATA[CTRL_INV];
`ifdef ENC_INDEX_EN
            ctrl.zclr <= S_AXI_WDATA[CTRL_ZCLR];
`endif
          end
          REG_PRESET: preset <= strb_merge(preset, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end

      if (load)
        pos <= preset;
      else if (idx_clr)
        pos <= '0;
      else if (cnt_up)
        pos <= pos + 32'd1;
      else if (cnt_dn)
        pos <= pos - 32'd1;

      if (!load && !idx_clr && (cnt_up || cnt_dn))
        dir_q <= cnt_up;

      // A fresh event in the clearing cycle wins over the W1C.
      err_q <= dec_err || (err_q && !(st_w1c && S_AXI_WDATA[ST_ERR]));
`ifdef ENC_INDEX_EN
      idx_q <= dec_idx || (idx_q && !(st_w1c && S_AXI_WDATA[ST_IDX]));
`else
      idx_q <= 1'b0;
`endif
    end
  end

  logic unused_ok;
`ifdef ENC_INDEX_EN
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], dec_idx};
`endif

endmodule

// File: tb/tb_encoder_axil_slave.sv
// Scoreboard bench for encoder_axil_slave: register access, counting,
// wrap, error, back-pressure, reset and index behaviour.
module tb_encoder_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [1:0]  ab;
  logic        z;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] rd_q[$];
  logic [1:0]  b_q[$];

  always #5 ACLK = ~ACLK;

  encoder_axil_slave dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .ENC_A         (ab[1]),
    .ENC_B         (ab[0])
`ifdef ENC_INDEX_EN
    , .ENC_Z       (z)
`endif
  );

  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic steps(input int n, input bit fwd);
    repeat (n) begin
      @(negedge ACLK);
      ab = fwd ? fwd_of(ab) : rev_of(ab);
      @(negedge ACLK);
    end
    repeat (4) @(negedge ACLK);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int t;
    logic [1:0] eb;
    @(negedge ACLK);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    b_q.push_back(2'b00);
    t = 0;
    while (!(awready && wready) && t < 20) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < 20) begin @(negedge ACLK); t++; end
    eb = b_q.pop_front();
    n_chk++;
    if (bvalid !== 1'b1 || bresp !== eb) begin
      n_fail++;
      $display("FAIL write_resp addr=%h got bvalid=%b bresp=%b, required bvalid=1 bresp=%b", addr, bvalid, bresp, eb);
    end
    bready = 1'b1;
    @(negedge ACLK);
    bready = 1'b0;
  endtask

  task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string name);
    int t;
    logic [31:0] e;
    rd_q.push_back(exp);
    @(negedge ACLK);
    araddr = addr; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 20) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 20) begin @(negedge ACLK); t++; end
    e = rd_q.pop_front();
    n_chk++;
    if (rvalid !== 1'b1 || rdata !== e || rresp !== 2'b00) begin
      n_fail++;
      $display("FAIL %s got rvalid=%b rdata=%h rresp=%b, required 1/%h/00", name, rvalid, rdata, rresp, e);
    end
    rready = 1'b1;
    @(negedge ACLK);
    rready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge ACLK);
    n_chk++;
    if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got aw=%b w=%b b=%b ar=%b r=%b rdata=%h, required all 0",
               awready, wready, bvalid, arready, rvalid, rdata);
    end
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    n_chk++;
    if ({awready, wready, bvalid, arready, rvalid} !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs got aw=%b w=%b b=%b ar=%b r=%b, required all 0",
               awready, wready, bvalid, arready, rvalid);
    end
  endtask

  task automatic test_regs;
    wr(4'h0, 32'h1, 4'hF);
    wr(4'h4, 32'h2, 4'hF);
    wr(4'h8, 32'h3, 4'hF);
    wr(4'hC, 32'h4, 4'hF);
    rd(4'h0, 32'h1, "rb_ctrl");
    rd(4'h4, 32'h0, "rb_pos");
    rd(4'h8, 32'h3, "rb_preset");
    rd(4'hC, 32'h0, "rb_status");
  endtask

  task automatic test_count;
    wr(4'h0, 32'h1, 4'hF);
    steps(8, 1'b1);
    rd(4'h4, 32'd8, "pos_fwd8");
    rd(4'hC, 32'h1, "dir_up");
    steps(3, 1'b0);
    rd(4'h4, 32'd5, "pos_rev3");
    rd(4'hC, 32'h0, "dir_down");
    wr(4'h0, 32'h3, 4'hF);
    steps(2, 1'b1);
    rd(4'h4, 32'd3, "pos_inv");
    rd(4'hC, 32'h0, "dir_inv");
  endtask

  task automatic test_wrap;
    wr(4'h8, 32'hFFFF_FFFE, 4'hF);
    wr(4'h0, 32'h9, 4'hF);
    rd(4'h0, 32'h1, "ctrl_load_reads0");
    rd(4'h4, 32'hFFFF_FFFE, "pos_loaded");
    steps(3, 1'b1);
    rd(4'h4, 32'h0000_0001, "pos_wrap_u32");
    wr(4'h8, 32'h7FFF_FFFF, 4'hF);
    wr(4'h0, 32'h9, 4'hF);
    steps(1, 1'b1);
    rd(4'h4, 32'h8000_0000, "pos_wrap_s32");
    wr(4'h8, 32'hAABB_CCDD, 4'h3);
    rd(4'h8, 32'h7FFF_CCDD, "preset_wstrb");
    wr(4'h0, 32'h0, 4'h0);
    rd(4'h0, 32'h1, "ctrl_no_strb");
  endtask

  task automatic test_err;
    @(negedge ACLK);
    ab = ~ab;
    repeat (6) @(negedge ACLK);
    rd(4'h4, 32'h8000_0000, "pos_err_hold");
    rd(4'hC, 32'h3, "err_set");
    wr(4'hC, 32'h2, 4'hF);
    rd(4'hC, 32'h1, "err_w1c");
    wr(4'h4, 32'h55, 4'hF);
    rd(4'h4, 32'h8000_0000, "pos_ro");
  endtask

  task automatic test_back_to_back;
    int t;
    logic [31:0] e;
    @(negedge ACLK);
    awaddr = 4'h8; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    while (!awready && t < 20) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    wdata = 32'hCAFE_F00D;
    b_q.push_back(2'b00);
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0 || bresp !== b_q[0]) begin
        n_fail++;
        $display("FAIL b_stall cyc=%0d got bvalid=%b awready=%b wready=%b, required 1/0/0", i, bvalid, awready, wready);
      end
      @(negedge ACLK);
    end
    void'(b_q.pop_front());
    bready = 1'b1;
    @(negedge ACLK);
    bready = 1'b0;
    b_q.push_back(2'b00);
    t = 0;
    while (!awready && t < 20) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < 20) begin @(negedge ACLK); t++; end
    e = {30'b0, b_q.pop_front()};
    n_chk++;
    if (bvalid !== 1'b1 || bresp !== e[1:0]) begin
      n_fail++;
      $display("FAIL second_write got bvalid=%b bresp=%b, required 1/%b", bvalid, bresp, e[1:0]);
    end
    bready = 1'b1;
    @(negedge ACLK);
    bready = 1'b0;
    rd(4'h8, 32'hCAFE_F00D, "preset_2nd_write");

    rd_q.push_back(32'hCAFE_F00D);
    @(negedge ACLK);
    araddr = 4'h8; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 20) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    araddr = 4'h0;
    t = 0;
    while (!rvalid && t < 20) begin @(negedge ACLK); t++; end
    e = rd_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (rvalid !== 1'b1 || rdata !== e || arready !== 1'b0) begin
        n_fail++;
        $display("FAIL r_stall cyc=%0d got rvalid=%b rdata=%h arready=%b, required 1/%h/0", i, rvalid, rdata, arready, e);
      end
      @(negedge ACLK);
    end

    ab = 2'b00;
    ARESETN = 1'b0;
    #1;
    n_chk++;
    if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got aw=%b w=%b b=%b ar=%b r=%b rdata=%h, required all 0",
               awready, wready, bvalid, arready, rvalid, rdata);
    end
    arvalid = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    rd(4'h0, 32'h0, "rst_ctrl");
    rd(4'h4, 32'h0, "rst_pos");
    rd(4'h8, 32'h0, "rst_preset");
    rd(4'hC, 32'h0, "rst_status");
  endtask

  task automatic test_index;
`ifdef ENC_INDEX_EN
    wr(4'h0, 32'h5, 4'hF);
    wr(4'h8, 32'd20, 4'hF);
    wr(4'h0, 32'hD, 4'hF);
    rd(4'h4, 32'd20, "idx_preload");
    rd(4'h0, 32'h5, "ctrl_zclr");
    @(negedge ACLK);
    z = 1'b1;
    repeat (3) @(negedge ACLK);
    z = 1'b0;
    repeat (4) @(negedge ACLK);
    rd(4'h4, 32'h0, "idx_clear");
    rd(4'hC, 32'h4, "idx_set");
    wr(4'hC, 32'h4, 4'hF);
    rd(4'hC, 32'h0, "idx_w1c");
`else
    wr(4'h0, 32'h4, 4'hF);
    rd(4'h0, 32'h0, "zclr_absent");
    wr(4'hC, 32'h4, 4'hF);
    rd(4'hC, 32'h0, "idx_absent");
`endif
  endtask

  initial begin
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0; ab = 2'b00; z = 1'b0;
    test_reset;
    test_regs;
    test_count;
    test_wrap;
    test_err;
    test_back_to_back;
    test_index;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
